spi_mosi_tx: RTL and testbench
==============================

Name: spi_mosi_tx

Overview:
SPI master transmitter. It generates SCLK and SS and shifts a FRAME_BITS-wide word out on MOSI, MSB first, in SPI mode 0 (CPOL=0, CPHA=0). It is the outbound counterpart of the 40-bit MISO capture block on the same peripheral link, and carries command/LED bytes to the joystick/servo-side SPI device. A start/busy/done handshake hooks it to the control FSM.

Parameters:
FRAME_BITS, 40, bits per frame; must be a multiple of 8.
CLK_DIV, 50, clk cycles per SCLK half-period; must be >=1.
SS_SETUP, 3, clk cycles SS is low before the first SCLK low phase, and after the last SCLK fall before SS rises; must be >=1.
BYTE_GAP, 0, extra clk cycles SCLK is held low between bytes; 0 means no gap.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  frame request; sampled only when busy=0
DIN  in  FRAME_BITS  frame data; captured on the edge that accepts start
busy  out  1  high while a frame is in progress
done  out  1  one-cycle pulse at frame end
SS  out  1  slave select, active-low
SCLK  out  1  serial clock, idles low
MOSI  out  1  serial data out, idles 0

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-frame): SS=1, SCLK=0, MOSI=0, busy=0, done=0, FSM=IDLE, counters=0. An aborted frame produces no done.
- FSM states: IDLE, SETUP, LOW, HIGH, GAP, HOLD.
- IDLE:
  - SS=1, SCLK=0, MOSI=0.
  - On an edge with start=1 and busy=0: latch DIN into the shift register, SS<=0, MOSI<=DIN[FRAME_BITS-1], busy<=1; go to SETUP.
- SETUP: SCLK=0 for SS_SETUP cycles, then go to LOW.
- LOW: SCLK=0 for CLK_DIV cycles, then SCLK<=1 and go to HIGH. The slave samples MOSI on this rising edge.
- HIGH: SCLK=1 for CLK_DIV cycles. At the end of the phase, SCLK<=0 and the bit counter increments. Then:
  - If bits sent == FRAME_BITS: go to HOLD.
  - Otherwise MOSI<=next bit on the same edge as the SCLK fall.
  - If bits sent is a multiple of 8 and BYTE_GAP>0: go to GAP.
  - Otherwise: go to LOW.
- GAP: SCLK=0 and MOSI holds the next byte's MSB for BYTE_GAP cycles, then go to LOW.
- HOLD: SCLK=0 for SS_SETUP cycles. MOSI holds the last bit. Then, on one edge: SS<=1, MOSI<=0, busy<=0, done<=1; go to IDLE.
- done is high for exactly one cycle (the first IDLE cycle).
- start=1 in the done cycle is accepted, so back-to-back frames have a minimum SS-high time of 1 cycle.
- start while busy=1 is ignored, and DIN changes during a frame are ignored.
- Exactly FRAME_BITS SCLK rising edges per frame. No glitches: SCLK, SS and MOSI are registered outputs.
- SS low duration = 2*SS_SETUP + FRAME_BITS*2*CLK_DIV + (FRAME_BITS/8-1)*BYTE_GAP cycles.
- Counters must be sized for the maximum of CLK_DIV, SS_SETUP and BYTE_GAP, and for FRAME_BITS; no wrap-around is permitted within a phase.

Test Plan:
Bench parameters: CLK_DIV=2, SS_SETUP=3, BYTE_GAP=4, FRAME_BITS=40.
1. Reset: hold rst for 3 cycles, then toggle start and DIN with rst still high -> SS=1, SCLK=0, MOSI=0, busy=0, done=0 throughout.
2. Single frame, DIN=40'hA53C0FF081, start pulsed for 1 cycle -> a monitor capturing MOSI on SCLK rises reads 40'hA53C0FF081; exactly 40 rises; SS low for exactly 182 cycles; done high for 1 cycle, coincident with SS rising; busy low from that same cycle.
3. start re-pulsed mid-frame with DIN=40'h0 -> ignored; the captured word is still 40'hA53C0FF081; only one done.
4. Byte gap: SCLK low time between the 8th fall and the 9th rise = 6 cycles; all other intra-byte low times = 2 cycles. Re-run with BYTE_GAP=0 -> uniform 2-cycle low times and SS low for 166 cycles.
5. Back-to-back: start held high, DIN=40'hFFFFFFFFFF then 40'h0000000001 -> SS high for exactly 1 cycle between frames; both words captured correctly; 2 done pulses.
6. rst asserted for 1 cycle after the 20th SCLK rise -> next cycle SS=1, SCLK=0, MOSI=0, busy=0; no done; a following start sends a complete correct frame.

Source files
------------

// File: rtl/spi_mosi_tx_if.sv
// Handshake and serial-line bundle for the SPI MOSI transmitter.
// master = control FSM side, slave = the transmitter itself.
interface spi_mosi_tx_if #(
   parameter int FRAME_BITS = 40
);
   logic                  start;
   logic [FRAME_BITS-1:0] DIN;
   logic                  busy;
   logic                  done;
   logic                  SS;
   logic                  SCLK;
   logic                  MOSI;

   modport master (output start, DIN, input busy, done, SS, SCLK, MOSI);
   modport slave  (input start, DIN, output busy, done, SS, SCLK, MOSI);
endinterface

// File: rtl/spi_mosi_tx.sv
// SPI mode-0 master transmitter: shifts a FRAME_BITS word out MSB first with SS/SCLK framing.
// start is taken only while idle; SS low for 2*SS_SETUP + 2*CLK_DIV*FRAME_BITS + (FRAME_BITS/8-1)*BYTE_GAP cycles.
module spi_mosi_tx #(
   parameter int FRAME_BITS = 40,
   parameter int CLK_DIV    = 50,
   parameter int SS_SETUP   = 3,
   parameter int BYTE_GAP   = 0
) (
   input  logic         clk,
   input  logic         rst,
   spi_mosi_tx_if.slave bus
);
   localparam int MAX_A  = (CLK_DIV > SS_SETUP) ? CLK_DIV : SS_SETUP;
   localparam int MAX_PH = (MAX_A > BYTE_GAP) ? MAX_A : BYTE_GAP;
   localparam int PW     = (MAX_PH < 2) ? 1 : $clog2(MAX_PH);
   localparam int BW     = $clog2(FRAME_BITS + 1);

   localparam logic [PW-1:0] DIV_LAST   = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] SETUP_LAST = PW'(SS_SETUP - 1);
   localparam logic [PW-1:0] GAP_LAST   = (BYTE_GAP > 0) ? PW'(BYTE_GAP - 1) : '0;
   localparam logic [BW-1:0] LAST_BIT   = BW'(FRAME_BITS);

   typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, GAP, HOLD} state_t;

   state_t                state;
   logic [PW-1:0]         ph;
   logic [BW-1:0]         bits;
   logic [BW-1:0]         bits_nxt;
   logic [FRAME_BITS-1:0] shreg;

   assign bits_nxt = bits + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ph       <= '0;
         bits     <= '0;
         shreg    <= '0;
         bus.SS   <= 1'b1;
         bus.SCLK <= 1'b0;
         bus.MOSI <= 1'b0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  shreg    <= bus.DIN;
                  bus.SS   <= 1'b0;
                  bus.MOSI <= bus.DIN[FRAME_BITS-1];
                  bus.busy <= 1'b1;
                  ph       <= '0;
                  bits     <= '0;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               if (ph == SETUP_LAST) begin
                  ph    <= '0;
                  state <= LOW;
               end else begin
                  ph <= ph + 1'b1;
               end
            end
            LOW: begin
               if (ph == DIV_LAST) begin
                  ph       <= '0;
                  bus.SCLK <= 1'b1;
                  state    <= HIGH;
               end else begin
                  ph <= ph + 1'b1;
               end
            end
            HIGH: begin
               if (ph == DIV_LAST) begin
                  ph       <= '0;
                  bus.SCLK <= 1'b0;
                  bits     <= bits_nxt;
                  if (bits_nxt == LAST_BIT) begin
                     state <= HOLD;
                  end else begin
                     // next bit changes on the SCLK fall so it is stable for a full low phase
                     shreg    <= shreg << 1;
                     bus.MOSI <= shreg[FRAME_BITS-2];
                     state    <= (BYTE_GAP > 0 && bits_nxt[2:0] == 3'd0) ? GAP : LOW;
                  end
               end else begin
                  ph <= ph + 1'b1;
               end
            end
            GAP: begin
               if (ph == GAP_LAST) begin
                  ph    <= '0;
                  state <= LOW;
               end else begin
                  ph <= ph + 1'b1;
               end
            end
            HOLD: begin
               if (ph == SETUP_LAST) begin
                  ph       <= '0;
                  bits     <= '0;
                  bus.SS   <= 1'b1;
                  bus.MOSI <= 1'b0;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  state    <= IDLE;
               end else begin
                  ph <= ph + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_mosi_tx.sv
// Bench for spi_mosi_tx: two instances (BYTE_GAP=4 and BYTE_GAP=0) observed by line-level monitors.
module tb_spi_mosi_tx;
   localparam int FB = 40;
   localparam int CLK_DIV = 2;
   localparam int SS_SETUP = 3;
   localparam int GAP_G = 4;
   localparam int GAP_N = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_mosi_tx_if #(.FRAME_BITS(FB)) ifg ();
   spi_mosi_tx_if #(.FRAME_BITS(FB)) ifn ();

   spi_mosi_tx #(.FRAME_BITS(FB), .CLK_DIV(CLK_DIV), .SS_SETUP(SS_SETUP), .BYTE_GAP(GAP_G))
      dut_g (.clk(clk), .rst(rst), .bus(ifg));
   spi_mosi_tx #(.FRAME_BITS(FB), .CLK_DIV(CLK_DIV), .SS_SETUP(SS_SETUP), .BYTE_GAP(GAP_N))
      dut_n (.clk(clk), .rst(rst), .bus(ifn));

   logic [1:0] m_ss, m_sclk, m_mosi, m_done, m_busy;
   assign m_ss   = {ifn.SS,   ifg.SS};
   assign m_sclk = {ifn.SCLK, ifg.SCLK};
   assign m_mosi = {ifn.MOSI, ifg.MOSI};
   assign m_done = {ifn.done, ifg.done};
   assign m_busy = {ifn.busy, ifg.busy};

   // Reconstructs each frame from the pins alone: bits sampled on SCLK rises, SS-low length, low phases.
   for (genvar g = 0; g < 2; g++) begin : mon
      logic p_sclk = 1'b0;
      logic p_ss = 1'b1;
      logic [FB-1:0] word = '0;
      int rises = 0, ss_len = 0, hi_len = 0, low_len = 0;
      bit aborted = 1'b0;
      int nfr = 0, ndone = 0, stray = 0, nabort = 0, last_hi = -1;
      logic [FB-1:0] fw [64];
      int frise [64];
      int flen [64];
      bit fdok [64];
      int lows [FB];

      always @(negedge clk) begin
         if (rst && !m_ss[g]) aborted = 1'b1;
         if (m_done[g] === 1'b1) begin
            ndone++;
            if (!(m_ss[g] && !p_ss && !aborted)) stray++;
         end
         if (m_ss[g] === 1'b0) begin
            if (p_ss) begin
               last_hi = hi_len;
               word = '0; rises = 0; ss_len = 0; low_len = 0;
               aborted = rst;
            end
            ss_len++;
            if (m_sclk[g] && !p_sclk) begin
               word = {word[FB-2:0], m_mosi[g]};
               if (rises < FB) lows[rises] = low_len;
               rises++;
               low_len = 0;
            end else if (!m_sclk[g]) begin
               low_len++;
            end
         end else if (m_ss[g] === 1'b1) begin
            if (!p_ss) begin
               if (aborted) nabort++;
               else if (nfr < 64) begin
                  fw[nfr] = word; frise[nfr] = rises; flen[nfr] = ss_len;
                  fdok[nfr] = m_done[g] && !m_busy[g];
                  nfr++;
               end
               hi_len = 0;
            end
            hi_len++;
         end
         p_ss = (m_ss[g] === 1'b0) ? 1'b0 : 1'b1;
         p_sclk = (m_sclk[g] === 1'b1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int nfr_of(input int g);
      return (g == 0) ? mon[0].nfr : mon[1].nfr;
   endfunction
   function automatic int ndone_of(input int g);
      return (g == 0) ? mon[0].ndone : mon[1].ndone;
   endfunction
   function automatic int low_of(input int g, input int k);
      return (g == 0) ? mon[0].lows[k] : mon[1].lows[k];
   endfunction

   task automatic get_frame(input int g, input int idx, output logic [FB-1:0] w,
                            output int r, output int len, output bit dok);
      if (g == 0) begin
         w = mon[0].fw[idx]; r = mon[0].frise[idx]; len = mon[0].flen[idx]; dok = mon[0].fdok[idx];
      end else begin
         w = mon[1].fw[idx]; r = mon[1].frise[idx]; len = mon[1].flen[idx]; dok = mon[1].fdok[idx];
      end
   endtask

   task automatic wait_nfr(input int g, input int target);
      int budget = 3000;
      while (nfr_of(g) < target && budget > 0) begin
         tick();
         budget--;
      end
      check("frame_timeout", nfr_of(g) >= target, 1);
   endtask

   // Reference rules: frame length and SCLK low phase lengths from the timing parameters.
   function automatic int exp_len(input int gap);
      return 2 * SS_SETUP + FB * 2 * CLK_DIV + (FB / 8 - 1) * gap;
   endfunction
   function automatic int exp_low(input int k, input int gap);
      if (k == 0) return SS_SETUP + CLK_DIV;
      return CLK_DIV + ((k % 8 == 0) ? gap : 0);
   endfunction

   task automatic check_frame(input string name, input int g, input int idx,
                              input logic [FB-1:0] exp_w, input int gap);
      logic [FB-1:0] w;
      int r, len;
      bit dok;
      get_frame(g, idx, w, r, len, dok);
      check({name, "_word"}, w, exp_w);
      check({name, "_rises"}, r, FB);
      check({name, "_ss_low"}, len, exp_len(gap));
      check({name, "_done_at_ss_rise"}, dok, 1);
   endtask

   typedef struct {
      logic [FB-1:0] din;
      bit            glitch;
      logic [FB-1:0] exp_word;
      int            exp_len_g;
      int            exp_len_n;
   } vec_t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [5];
      logic [FB-1:0] exp_q [$];
      logic [63:0] rnd;
      int n0, n1, d0, d1, a0, budget;

      tbl[0] = '{40'hA53C0FF081, 1'b1, 40'hA53C0FF081, 182, 166};
      tbl[1] = '{40'h0000000000, 1'b0, 40'h0000000000, 182, 166};
      tbl[2] = '{40'h8000000000, 1'b1, 40'h8000000000, 182, 166};
      tbl[3] = '{40'h5555555555, 1'b0, 40'h5555555555, 182, 166};
      tbl[4] = '{40'h00000000FF, 1'b1, 40'h00000000FF, 182, 166};

      ifg.start = 1'b0; ifg.DIN = '0;
      ifn.start = 1'b0; ifn.DIN = '0;

      // reset held while start/DIN toggle
      repeat (3) tick();
      for (int i = 0; i < 6; i++) begin
         rnd = {$urandom, $urandom};
         ifg.start = i[0]; ifg.DIN = rnd[FB-1:0];
         ifn.start = i[0]; ifn.DIN = ~rnd[FB-1:0];
         tick();
         check("rst_outputs_g", {ifg.SS, ifg.SCLK, ifg.MOSI, ifg.busy, ifg.done}, 5'b10000);
         check("rst_outputs_n", {ifn.SS, ifn.SCLK, ifn.MOSI, ifn.busy, ifn.done}, 5'b10000);
      end
      ifg.start = 1'b0; ifn.start = 1'b0;
      rst = 1'b0;
      tick();
      check("idle_after_rst", {ifg.SS, ifg.SCLK, ifg.MOSI, ifg.busy, ifg.done}, 5'b10000);

      // table frames, both gap settings in parallel, optional ignored mid-frame start
      for (int i = 0; i < 5; i++) begin
         n0 = nfr_of(0); n1 = nfr_of(1); d0 = ndone_of(0); d1 = ndone_of(1);
         ifg.start = 1'b1; ifg.DIN = tbl[i].din;
         ifn.start = 1'b1; ifn.DIN = tbl[i].din;
         tick();
         check("busy_after_start", {ifg.busy, ifn.busy, ifg.SS, ifn.SS}, 4'b1100);
         ifg.start = 1'b0; ifg.DIN = ~tbl[i].din;
         ifn.start = 1'b0; ifn.DIN = ~tbl[i].din;
         if (tbl[i].glitch) begin
            repeat (40) tick();
            ifg.start = 1'b1; ifg.DIN = '0;
            ifn.start = 1'b1; ifn.DIN = '0;
            tick();
            ifg.start = 1'b0; ifn.start = 1'b0;
         end
         wait_nfr(1, n1 + 1);
         wait_nfr(0, n0 + 1);
         check_frame("tbl_g", 0, n0, tbl[i].exp_word, GAP_G);
         check_frame("tbl_n", 1, n1, tbl[i].exp_word, GAP_N);
         check("tbl_len_g_const", exp_len(GAP_G), tbl[i].exp_len_g);
         check("tbl_len_n_const", exp_len(GAP_N), tbl[i].exp_len_n);
         check("tbl_one_done_g", ndone_of(0) - d0, 1);
         check("tbl_one_done_n", ndone_of(1) - d1, 1);
         if (i == 0) begin
            for (int k = 0; k < FB; k++) begin
               check($sformatf("low_g_%0d", k), low_of(0, k), exp_low(k, GAP_G));
               check($sformatf("low_n_%0d", k), low_of(1, k), exp_low(k, GAP_N));
            end
         end
         repeat (2) tick();
      end

      // back-to-back with start held high
      n0 = nfr_of(0); d0 = ndone_of(0);
      ifg.start = 1'b1; ifg.DIN = 40'hFFFFFFFFFF;
      tick();
      ifg.DIN = 40'h0000000001;
      budget = 400;
      while (ifg.done !== 1'b1 && budget > 0) begin
         tick();
         budget--;
      end
      check("b2b_done_seen", ifg.done, 1);
      check("b2b_busy_low_at_done", ifg.busy, 0);
      tick();
      ifg.start = 1'b0;
      check("b2b_second_accepted", {ifg.busy, ifg.SS}, 2'b10);
      wait_nfr(0, n0 + 2);
      check_frame("b2b_f1", 0, n0, 40'hFFFFFFFFFF, GAP_G);
      check_frame("b2b_f2", 0, n0 + 1, 40'h0000000001, GAP_G);
      check("b2b_ss_high", mon[0].last_hi, 1);
      check("b2b_two_dones", ndone_of(0) - d0, 2);
      repeat (3) tick();

      // reset mid-frame after the 20th rise
      n0 = nfr_of(0); n1 = nfr_of(1); d0 = ndone_of(0); d1 = ndone_of(1); a0 = mon[0].nabort;
      ifg.start = 1'b1; ifg.DIN = 40'h123456789A;
      ifn.start = 1'b1; ifn.DIN = 40'h123456789A;
      tick();
      ifg.start = 1'b0; ifn.start = 1'b0;
      budget = 400;
      while (mon[0].rises < 20 && budget > 0) begin
         tick();
         budget--;
      end
      check("abort_reached_rise20", mon[0].rises >= 20, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_outputs_g", {ifg.SS, ifg.SCLK, ifg.MOSI, ifg.busy, ifg.done}, 5'b10000);
      check("abort_outputs_n", {ifn.SS, ifn.SCLK, ifn.MOSI, ifn.busy, ifn.done}, 5'b10000);
      repeat (200) tick();
      check("abort_no_done_g", ndone_of(0) - d0, 0);
      check("abort_no_done_n", ndone_of(1) - d1, 0);
      check("abort_no_frame", nfr_of(0) - n0, 0);
      check("abort_seen", mon[0].nabort - a0, 1);
      ifg.start = 1'b1; ifg.DIN = 40'hC3A5F00F1E;
      tick();
      ifg.start = 1'b0;
      wait_nfr(0, n0 + 1);
      check_frame("post_abort", 0, n0, 40'hC3A5F00F1E, GAP_G);

      // random frames with ignored start pulses while busy
      for (int r = 0; r < 6; r++) begin
         repeat ($urandom_range(0, 5)) tick();
         rnd = {$urandom, $urandom};
         exp_q.push_back(rnd[FB-1:0]);
         n0 = nfr_of(0);
         ifg.start = 1'b1; ifg.DIN = rnd[FB-1:0];
         tick();
         ifg.start = 1'b0; ifg.DIN = {$urandom, $urandom};
         repeat ($urandom_range(2, 150)) tick();
         ifg.start = 1'b1; ifg.DIN = {$urandom, $urandom};
         tick();
         ifg.start = 1'b0;
         wait_nfr(0, n0 + 1);
         check_frame("rand", 0, n0, exp_q.pop_front(), GAP_G);
      end

      check("stray_done_g", mon[0].stray, 0);
      check("stray_done_n", mon[1].stray, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
